mtr_cmd_seq: RTL and testbench

Motor command sequencer that sits between the navigation/command logic and `MtrDrv`. It accepts signed left/right speed targets through a valid/ready handshake and slews the `lft_spd`/`rght_spd` values it drives into `MtrDrv` toward those targets at a fixed rate. A side that must change direction is first ramped to zero, then held there for a dwell period. A filtered low-battery monitor on `vbatt` forces both speeds to zero and latches a fault.

---
 rtl/mtr_pkg.sv | 30 +++
 rtl/mtr_cmd_seq_spd_slew.sv | 43 ++++
 rtl/mtr_cmd_seq.sv | 206 ++++++++++++++++++++
 tb/tb_mtr_cmd_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mtr_pkg
// Description : Shared types, speed limits and helpers for the motor command
//               sequencer.
//               seq_state_t  - sequencer FSM state encoding
//               SPD_MAX/MIN  - legal signed speed range (symmetric, no -2048)
//               sgn_differs  - true when two speeds point in opposite
//                              directions
// Revision    : 1.0 - initial release
// ============================================================================
package mtr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_DWELL = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_t;

    localparam logic [11:0] SPD_MAX = 12'h7FF;
    localparam logic [11:0] SPD_MIN = 12'h801;

    // Zero has no direction, so a move to or from zero is never a reversal.
    function automatic logic sgn_differs(input logic [11:0] a, input logic [11:0] b);
        return (a != 12'h000) && (b != 12'h000) && (a[11] != b[11]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtr_cmd_seq_spd_slew.sv
`default_nettype none
// ============================================================================
// Module      : spd_slew
// Description : Combinational slew step for one motor side. Moves the
//               current speed toward the step target by at most STEP.
// Ports       : cur_i    - current signed speed
//               tgt_i    - signed step target (within SPD_MIN..SPD_MAX)
//               nxt_o    - speed after one slew step
//               at_tgt_o - nxt_o equals tgt_i
// Revision    : 1.0 - initial release
// ============================================================================
module spd_slew #(
    parameter logic [11:0] STEP = 12'h040
) (
    input  logic [11:0] cur_i,
    input  logic [11:0] tgt_i,
    output logic [11:0] nxt_o,
    output logic        at_tgt_o
);

    logic signed [12:0] w_diff;
    logic signed [12:0] w_step;

    // 13-bit difference cannot overflow for two 12-bit signed operands.
    assign w_diff = $signed({tgt_i[11], tgt_i}) - $signed({cur_i[11], cur_i});
    assign w_step = $signed({1'b0, STEP});

    // The add/subtract paths only run when the target lies strictly beyond
    // one full step, so the 12-bit result can neither wrap nor overshoot.
    always_comb begin
        if (w_diff > w_step) begin
            nxt_o = cur_i + STEP;
        end else if (w_diff < -w_step) begin
            nxt_o = cur_i - STEP;
        end else begin
            nxt_o = tgt_i;
        end
    end

    assign at_tgt_o = (nxt_o == tgt_i);

endmodule
`default_nettype wire

// File: rtl/mtr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : mtr_cmd_seq
// Description : Motor command sequencer. Accepts signed left/right speed
//               targets by valid/ready, slews the speeds driven to MtrDrv at a
//               fixed rate per tick, ramps through zero with a dwell on
//               direction reversal and zeroes both sides on a filtered
//               low-battery fault.
// Ports       : clk, rst_n            - clock, async active-low reset
//               cmd_vld_i / cmd_rdy_o - target handshake
//               lft_tgt_i, rght_tgt_i - signed targets
//               en_i                  - motion enable (low -> targets 0)
//               vbatt_i               - unsigned battery reading
//               clr_fault_i           - fault clear request
//               lft_spd_o, rght_spd_o - signed speeds to MtrDrv
//               busy_o, fault_o       - FSM not idle, latched battery fault
// Revision    : 1.0 - initial release
// ============================================================================
module mtr_cmd_seq
    import mtr_pkg::*;
#(
    parameter int          TICK_DIV  = 1024,
    parameter logic [11:0] STEP      = 12'h040,
    parameter int          REV_DWELL = 16,
    parameter logic [11:0] VBATT_MIN = 12'hC00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld_i,
    output logic        cmd_rdy_o,
    input  logic [11:0] lft_tgt_i,
    input  logic [11:0] rght_tgt_i,
    input  logic        en_i,
    input  logic [11:0] vbatt_i,
    input  logic        clr_fault_i,
    output logic [11:0] lft_spd_o,
    output logic [11:0] rght_spd_o,
    output logic        busy_o,
    output logic        fault_o
);

    localparam int TW    = (TICK_DIV  <= 2) ? 1 : $clog2(TICK_DIV);
    localparam int DW    = (REV_DWELL <= 2) ? 1 : $clog2(REV_DWELL);
    localparam int DLAST = (REV_DWELL > 0) ? REV_DWELL - 1 : 0;

    seq_state_t  state_q, state_d;
    logic [11:0] lft_q, lft_d, rght_q, rght_d;
    logic [11:0] lft_tgt_q, lft_tgt_d, rght_tgt_q, rght_tgt_d;
    logic        rev_l_q, rev_l_d, rev_r_q, rev_r_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]  bat_q, bat_d;
    logic        fault_q, fault_d;

    logic        w_tick, w_low, w_accept, w_fault_trig;
    logic [11:0] w_eff_l, w_eff_r, w_stp_l, w_stp_r, w_nxt_l, w_nxt_r;
    logic        w_rev_l, w_rev_r, w_at_l, w_at_r;

    assign w_tick    = (tick_q == TW'(TICK_DIV - 1));
    assign w_low     = (vbatt_i < VBATT_MIN);
    assign cmd_rdy_o = (state_q == ST_IDLE) && !fault_q;
    assign w_accept  = cmd_vld_i && cmd_rdy_o;

    assign w_eff_l = en_i ? lft_tgt_q  : 12'h000;
    assign w_eff_r = en_i ? rght_tgt_q : 12'h000;

    // Once a side has been pulled to zero for a reversal it stays parked
    // there (latched flag) until the dwell completes, even if the other side
    // is still slewing.
    assign w_rev_l = sgn_differs(lft_q,  w_eff_l) || rev_l_q;
    assign w_rev_r = sgn_differs(rght_q, w_eff_r) || rev_r_q;
    assign w_stp_l = w_rev_l ? 12'h000 : w_eff_l;
    assign w_stp_r = w_rev_r ? 12'h000 : w_eff_r;

    // Fourth consecutive low sample; overrides every other transition.
    assign w_fault_trig = w_tick && w_low && (bat_q == 2'd3) && (state_q != ST_FAULT);

    spd_slew #(.STEP(STEP)) u_slew_l (
        .cur_i    (lft_q),
        .tgt_i    (w_stp_l),
        .nxt_o    (w_nxt_l),
        .at_tgt_o (w_at_l)
    );

    spd_slew #(.STEP(STEP)) u_slew_r (
        .cur_i    (rght_q),
        .tgt_i    (w_stp_r),
        .nxt_o    (w_nxt_r),
        .at_tgt_o (w_at_r)
    );

    always_comb begin
        state_d    = state_q;
        lft_d      = lft_q;
        rght_d     = rght_q;
        lft_tgt_d  = lft_tgt_q;
        rght_tgt_d = rght_tgt_q;
        rev_l_d    = rev_l_q;
        rev_r_d    = rev_r_q;
        dwell_d    = dwell_q;
        fault_d    = fault_q;
        tick_d     = w_tick ? '0 : tick_q + TW'(1);
        bat_d      = bat_q;

        if (w_tick) begin
            if (w_low) begin
                bat_d = (bat_q == 2'd3) ? 2'd3 : bat_q + 2'd1;
            end else begin
                bat_d = 2'd0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    lft_tgt_d  = (lft_tgt_i  == 12'h800) ? SPD_MIN : lft_tgt_i;
                    rght_tgt_d = (rght_tgt_i == 12'h800) ? SPD_MIN : rght_tgt_i;
                    state_d    = ST_RAMP;
                end else if ((lft_q != w_eff_l) || (rght_q != w_eff_r)) begin
                    // Enable changed while idle: chase the new effective target.
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (w_tick) begin
                    lft_d   = w_nxt_l;
                    rght_d  = w_nxt_r;
                    rev_l_d = w_rev_l;
                    rev_r_d = w_rev_r;
                    if (w_at_l && w_at_r) begin
                        if (w_rev_l || w_rev_r) begin
                            state_d = ST_DWELL;
                            dwell_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DWELL: begin
                if (w_tick) begin
                    if (dwell_q == DW'(DLAST)) begin
                        state_d = ST_RAMP;
                        rev_l_d = 1'b0;
                        rev_r_d = 1'b0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (clr_fault_i && !w_low) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_fault_trig) begin
            state_d    = ST_FAULT;
            fault_d    = 1'b1;
            lft_d      = 12'h000;
            rght_d     = 12'h000;
            lft_tgt_d  = 12'h000;
            rght_tgt_d = 12'h000;
            rev_l_d    = 1'b0;
            rev_r_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lft_q      <= 12'h000;
            rght_q     <= 12'h000;
            lft_tgt_q  <= 12'h000;
            rght_tgt_q <= 12'h000;
            rev_l_q    <= 1'b0;
            rev_r_q    <= 1'b0;
            tick_q     <= '0;
            dwell_q    <= '0;
            bat_q      <= 2'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lft_q      <= lft_d;
            rght_q     <= rght_d;
            lft_tgt_q  <= lft_tgt_d;
            rght_tgt_q <= rght_tgt_d;
            rev_l_q    <= rev_l_d;
            rev_r_q    <= rev_r_d;
            tick_q     <= tick_d;
            dwell_q    <= dwell_d;
            bat_q      <= bat_d;
            fault_q    <= fault_d;
        end
    end

    assign lft_spd_o  = lft_q;
    assign rght_spd_o = rght_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign fault_o    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mtr_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mtr_cmd_seq
// Description : Directed self-checking bench for mtr_cmd_seq with
//               TICK_DIV=4, STEP=12'h100, REV_DWELL=2, VBATT_MIN=12'hC00.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [11:0] lft_tgt, rght_tgt;
    logic        en;
    logic [11:0] vbatt;
    logic        clr_fault;
    logic [11:0] lft_spd, rght_spd;
    logic        busy, fault;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;   // clocks since reset release; speed updates when cyc%4==0

    mtr_cmd_seq #(
        .TICK_DIV  (4),
        .STEP      (12'h100),
        .REV_DWELL (2),
        .VBATT_MIN (12'hC00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_vld_i   (cmd_vld),
        .cmd_rdy_o   (cmd_rdy),
        .lft_tgt_i   (lft_tgt),
        .rght_tgt_i  (rght_tgt),
        .en_i        (en),
        .vbatt_i     (vbatt),
        .clr_fault_i (clr_fault),
        .lft_spd_o   (lft_spd),
        .rght_spd_o  (rght_spd),
        .busy_o      (busy),
        .fault_o     (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next speed-update edge.
    task automatic tick_wait();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((cyc % 4) != 0) && (n < 8));
        if ((cyc % 4) != 0) begin
            checks++;
            errors++;
            $error("FAIL tick_timeout: observed cyc %0d expected multiple of 4", cyc);
        end
    endtask

    task automatic send(input logic [11:0] l, input logic [11:0] r);
        @(negedge clk);
        lft_tgt  = l;
        rght_tgt = r;
        cmd_vld  = 1'b1;
        @(posedge clk);
        #1;
        cmd_vld  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && (n < max_cyc)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idle_busy", {11'd0, busy}, 12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_vld = 1'b0; lft_tgt = '0; rght_tgt = '0;
        en = 1'b1; vbatt = 12'hFFF; clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_lft",   lft_spd,  12'h000);
        chk("rst_rght",  rght_spd, 12'h000);
        chk("rst_busy",  {11'd0, busy},    12'h000);
        chk("rst_fault", {11'd0, fault},   12'h000);
        chk("rst_rdy",   {11'd0, cmd_rdy}, 12'h001);

        // Basic ramp
        send(12'h3FF, 12'h200);
        chk("basic_busy", {11'd0, busy}, 12'h001);
        tick_wait(); chk("basic_l1", lft_spd, 12'h100); chk("basic_r1", rght_spd, 12'h100);
        tick_wait(); chk("basic_l2", lft_spd, 12'h200); chk("basic_r2", rght_spd, 12'h200);
        tick_wait(); chk("basic_l3", lft_spd, 12'h300); chk("basic_r3", rght_spd, 12'h200);
        tick_wait(); chk("basic_l4", lft_spd, 12'h3FF); chk("basic_r4", rght_spd, 12'h200);
        chk("basic_idle", {11'd0, busy},    12'h000);
        chk("basic_rdy",  {11'd0, cmd_rdy}, 12'h001);

        // Bring left to 200, then reverse to E00
        send(12'h200, 12'h200);
        wait_idle(40);
        chk("pre_rev_l", lft_spd, 12'h200);
        send(12'hE00, 12'h200);
        tick_wait(); chk("rev_1", lft_spd, 12'h100);
        tick_wait(); chk("rev_2", lft_spd, 12'h000);
        tick_wait(); chk("rev_dw1", lft_spd, 12'h000); chk("rev_dw1_busy", {11'd0, busy}, 12'h001);
        tick_wait(); chk("rev_dw2", lft_spd, 12'h000);
        tick_wait(); chk("rev_3", lft_spd, 12'hF00);
        tick_wait(); chk("rev_4", lft_spd, 12'hE00); chk("rev_r", rght_spd, 12'h200);
        chk("rev_idle", {11'd0, busy}, 12'h000);

        // Clamp, with an ignored command while busy
        send(12'h800, 12'h200);
        tick_wait(); chk("clamp_1", lft_spd, 12'hD00);
        @(negedge clk);
        lft_tgt = 12'h000; rght_tgt = 12'h000; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("clamp_busy", {11'd0, busy}, 12'h001);
        wait_idle(60);
        chk("clamp_l", lft_spd,  12'h801);
        chk("clamp_r", rght_spd, 12'h200);

        // Enable drop from 300
        send(12'h300, 12'h000);
        wait_idle(120);
        chk("pre_en_l", lft_spd,  12'h300);
        chk("pre_en_r", rght_spd, 12'h000);
        @(negedge clk); en = 1'b0;
        @(posedge clk); #1;
        chk("en_busy", {11'd0, busy}, 12'h001);
        tick_wait(); chk("en_1", lft_spd, 12'h200);
        tick_wait(); chk("en_2", lft_spd, 12'h100);
        tick_wait(); chk("en_3", lft_spd, 12'h000);
        chk("en_idle", {11'd0, busy}, 12'h000);
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        tick_wait(); chk("en_res1", lft_spd, 12'h100);
        wait_idle(40);
        chk("en_res_l", lft_spd, 12'h300);

        // Low battery during a ramp
        send(12'h7FF, 12'h7FF);
        @(negedge clk); vbatt = 12'hB00;
        tick_wait(); chk("bat_l1", lft_spd, 12'h400); chk("bat_r1", rght_spd, 12'h100);
        tick_wait(); chk("bat_l2", lft_spd, 12'h500);
        tick_wait(); chk("bat_l3", lft_spd, 12'h600); chk("bat_f3", {11'd0, fault}, 12'h000);
        tick_wait();
        chk("bat_l4",   lft_spd,  12'h000);
        chk("bat_r4",   rght_spd, 12'h000);
        chk("bat_f4",   {11'd0, fault},   12'h001);
        chk("bat_rdy4", {11'd0, cmd_rdy}, 12'h000);
        @(negedge clk); clr_fault = 1'b1;
        @(negedge clk); clr_fault = 1'b0;
        chk("bat_clr_low", {11'd0, fault}, 12'h001);
        vbatt = 12'hD00;
        @(negedge clk); clr_fault = 1'b1;
        @(negedge clk); clr_fault = 1'b0;
        chk("bat_clr_f",    {11'd0, fault},   12'h000);
        chk("bat_clr_busy", {11'd0, busy},    12'h000);
        chk("bat_clr_rdy",  {11'd0, cmd_rdy}, 12'h001);
        tick_wait();
        chk("bat_post_l", lft_spd, 12'h000);

        // Asynchronous reset mid-ramp
        vbatt = 12'hFFF;
        send(12'h400, 12'hC00);
        tick_wait(); chk("rs_l1", lft_spd, 12'h100); chk("rs_r1", rght_spd, 12'hF00);
        tick_wait(); chk("rs_l2", lft_spd, 12'h200); chk("rs_r2", rght_spd, 12'hE00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_lft",   lft_spd,  12'h000);
        chk("rs_rght",  rght_spd, 12'h000);
        chk("rs_busy",  {11'd0, busy},    12'h000);
        chk("rs_fault", {11'd0, fault},   12'h000);
        chk("rs_rdy",   {11'd0, cmd_rdy}, 12'h001);
        @(negedge clk); rst_n = 1'b1;
        send(12'h100, 12'h000);
        chk("rs2_busy", {11'd0, busy}, 12'h001);
        tick_wait(); chk("rs2_l1", lft_spd, 12'h100); chk("rs2_r1", rght_spd, 12'h000);
        chk("rs2_idle", {11'd0, busy}, 12'h000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
